hedios_host: RTL and testbench
==============================

# hedios_host

Hardware Hedios client: issues Hedios commands from local FPGA logic and decodes endpoint responses. It is the initiator end of the link that HediosController answers. It sits between a request port driven by local logic and a pair of packet FIFOs (8-bit command + 32-bit data), which the serial transport links to a remote Hedios endpoint. It keeps a local mirror of the remote slots and the remote capability counts.

## Interface
- SLOT_COUNT, 8: number of mirrored remote slots, 1..128.
- TIMEOUT_CYCLES, 65535: idle cycles allowed while awaiting a response, ≥2.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  3  0 PING, 1 UPDATE_SLOT, 2 UPDATE_ALL_SLOT, 3 ASK_SLOT_COUNT, 4 ASK_ACTION_COUNT, 5 RESET, 6 VAR_ACTION, 7 VARLESS_ACTION.
- req_id  in  7  slot id (op 1) or action id (ops 6/7, low 6 bits).
- req_data  in  32  VAR_ACTION parameter.
- tx_full  in  1  tx packet FIFO full.
- tx_command  out  8  command of pushed packet.
- tx_data  out  32  data of pushed packet.
- tx_push_packet  out  1  one-cycle push strobe.
- rx_empty  in  1  rx packet FIFO empty.
- rx_command  in  8  head packet command, valid the cycle after rx_pop_packet.
- rx_data  in  32  head packet data, same timing.
- rx_pop_packet  out  1  one-cycle pop strobe.
- done  out  1  one-cycle completion pulse.
- resp_status  out  3  0 OK, 1 TIMEOUT, 2 INVALID_SLOT, 3 INVALID_ACTION, 4 UNKNOWN_COMMAND; valid with done.
- resp_data  out  32  op 3/4 payload; 0 otherwise; valid with done.
- slot_values  out  SLOT_COUNT×32  mirrored slot values.
- slot_valid  out  SLOT_COUNT  slot has been written at least once.
- slot_update  out  1  one-cycle pulse when a mirror entry is written.
- slot_update_id  out  7  id written, valid with slot_update.
- remote_slot_count  out  8  last reported slot count.
- remote_var_action_count  out  8  last reported var-action count.
- remote_varless_action_count  out  8  last reported varless-action count.
- rx_unexpected  out  1  one-cycle pulse when a popped packet is discarded.

## Operation
- States: IDLE, SEND, WAIT_RESP, POP, DECODE, FINISH.
- IDLE: req_ready=1. On req_valid, latch op/id/data, go to SEND. If no request and ~rx_empty, pop and decode an unsolicited packet.
- SEND: when ~tx_full, pulse tx_push_packet and drive the encoding:
  - PING: 0x01, data 0.
  - UPDATE_SLOT: 0x02, data {25'b0,id}.
  - UPDATE_ALL_SLOT: 0x03, data 0.
  - ASK_SLOT_COUNT: 0x04, data 0.
  - ASK_ACTION_COUNT: 0x05, data 0.
  - RESET: 0x55, data 0.
  - VAR_ACTION: {2'b11,id[5:0]}, data = req_data.
  - VARLESS_ACTION: {2'b10,id[5:0]}, data 0.
  - Ops 5/6/7 expect no response and go to FINISH with OK. All others go to WAIT_RESP with the timeout counter cleared.
- WAIT_RESP: if ~rx_empty, pulse rx_pop_packet and go to POP. Otherwise increment the counter; at TIMEOUT_CYCLES go to FINISH with TIMEOUT.
- POP: single wait cycle, then DECODE.
- DECODE, applied in priority order:
  - Command[7]=1 (slot packet, id = command[6:0]): if id < SLOT_COUNT, write slot_values[id]=rx_data, set slot_valid[id], pulse slot_update. Ids ≥ SLOT_COUNT are not stored.
  - This packet completes the request with OK when the op is UPDATE_SLOT and id == latched id, or when the op is UPDATE_ALL_SLOT and id == SLOT_COUNT-1.
  - 0x03 with op PING completes with OK.
  - 0x05 with op 3: remote_slot_count = data[7:0], resp_data = data; completes with OK.
  - 0x06 with op 4: remote_var_action_count = data[7:0], remote_varless_action_count = data[15:8], resp_data = data; completes with OK.
  - 0x09 / 0x0a / 0x0b complete a pending request with INVALID_SLOT / INVALID_ACTION / UNKNOWN_COMMAND.
  - Anything else, including 0x01 and 0x04, and any packet decoded from IDLE that is not a slot packet: discard and pulse rx_unexpected.
  - If not complete, return to WAIT_RESP (or IDLE if the packet was unsolicited) and clear the timeout counter.
- FINISH: pulse done with resp_status and resp_data, then go to IDLE.

## Timing
- Reset: all outputs 0, slot_values 0, slot_valid 0, state IDLE; req_ready goes to 1 the first cycle after rst deasserts.
- Reset mid-operation aborts immediately. No done is issued and no further push or pop occurs.
- Request accepted at cycle 0. The earliest tx_push_packet is at cycle 1 and is held off one cycle per tx_full cycle.
- For ops 5/6/7, done is pulsed the cycle after the push.
- Response latency: rx_pop_packet pulses 1 cycle after ~rx_empty is seen in WAIT_RESP. DECODE follows 2 cycles after the pop, and done 1 cycle after DECODE.
- At most one pop is outstanding; rx_pop_packet is never asserted on consecutive cycles.
- The timeout counter is sized to hold TIMEOUT_CYCLES and is cleared on every popped packet. Timeout fires after exactly TIMEOUT_CYCLES consecutive empty cycles.
- The counters latch the low byte(s) of rx_data verbatim, with no range checking.

## Test plan
- PING; endpoint replies 0x03 after 10 cycles -> one 0x01 push, one pop, done with status 0, resp_data 0.
- UPDATE_SLOT id 2; reply {0x82, 0xDEADBEEF} -> slot_values[2]=0xDEADBEEF, slot_valid[2]=1, slot_update with id 2, done OK.
- UPDATE_ALL_SLOT, SLOT_COUNT=4; replies 0x80..0x83 carrying 1,2,3,4 -> four slot_update pulses, done only after 0x83, slot_valid=4'hF.
- ASK_ACTION_COUNT; reply {0x06, 0x0000_0305} -> remote_var_action_count=5, remote_varless_action_count=3, resp_data=0x305.
- VAR_ACTION id 7, data 0x1234, tx_full held 3 cycles -> push {0xC7, 0x1234} at cycle 4, done at cycle 5.
- PING with no reply, TIMEOUT_CYCLES=16 -> done with status 1 after 16 empty cycles. A 0x04 received while waiting -> rx_unexpected pulses and the timeout restarts.

Source files
------------

// File: rtl/hedios_host.sv
// rtl/hedios_host.sv - Hedios initiator: issues commands, decodes responses, mirrors remote slots
module hedios_host #(
    parameter int SLOT_COUNT     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [6:0]               req_id,
    input  logic [31:0]              req_data,
    input  logic                     tx_full,
    output logic [7:0]               tx_command,
    output logic [31:0]              tx_data,
    output logic                     tx_push_packet,
    input  logic                     rx_empty,
    input  logic [7:0]               rx_command,
    input  logic [31:0]              rx_data,
    output logic                     rx_pop_packet,
    output logic                     done,
    output logic [2:0]               resp_status,
    output logic [31:0]              resp_data,
    output logic [SLOT_COUNT*32-1:0] slot_values,
    output logic [SLOT_COUNT-1:0]    slot_valid,
    output logic                     slot_update,
    output logic [6:0]               slot_update_id,
    output logic [7:0]               remote_slot_count,
    output logic [7:0]               remote_var_action_count,
    output logic [7:0]               remote_varless_action_count,
    output logic                     rx_unexpected
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEND   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_POP    = 3'd3;
    localparam logic [2:0] S_DECODE = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [2:0] OP_PING        = 3'd0;
    localparam logic [2:0] OP_UPDATE_SLOT = 3'd1;
    localparam logic [2:0] OP_UPDATE_ALL  = 3'd2;
    localparam logic [2:0] OP_ASK_SLOTS   = 3'd3;
    localparam logic [2:0] OP_ASK_ACTIONS = 3'd4;
    localparam logic [2:0] OP_RESET       = 3'd5;
    localparam logic [2:0] OP_VAR_ACTION  = 3'd6;

    localparam logic [2:0] ST_OK             = 3'd0;
    localparam logic [2:0] ST_TIMEOUT        = 3'd1;
    localparam logic [2:0] ST_INVALID_SLOT   = 3'd2;
    localparam logic [2:0] ST_INVALID_ACTION = 3'd3;
    localparam logic [2:0] ST_UNKNOWN_CMD    = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [2:0]               op_q, op_d;
    logic [6:0]               id_q, id_d;
    logic [31:0]              arg_q, arg_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     pop_q, pop_d;
    logic                     unsol_q, unsol_d;
    logic [7:0]               cmd_q, cmd_d;
    logic [31:0]              rxd_q, rxd_d;
    logic [2:0]               status_q, status_d;
    logic [31:0]              resp_q, resp_d;
    logic [SLOT_COUNT*32-1:0] slots_q, slots_d;
    logic [SLOT_COUNT-1:0]    valid_q, valid_d;
    logic                     upd_q, upd_d;
    logic [6:0]               upd_id_q, upd_id_d;
    logic [7:0]               rsc_q, rsc_d;
    logic [7:0]               rvac_q, rvac_d;
    logic [7:0]               rvlac_q, rvlac_d;
    logic                     unexp_q, unexp_d;
    logic                     alive_q, alive_d;
    logic                     complete_c;

    // Request/response sequencing, packet decode and mirror update
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        id_d       = id_q;
        arg_d      = arg_q;
        cnt_d      = cnt_q;
        pop_d      = 1'b0;
        unsol_d    = unsol_q;
        cmd_d      = cmd_q;
        rxd_d      = rxd_q;
        status_d   = status_q;
        resp_d     = resp_q;
        slots_d    = slots_q;
        valid_d    = valid_q;
        upd_d      = 1'b0;
        upd_id_d   = upd_id_q;
        rsc_d      = rsc_q;
        rvac_d     = rvac_q;
        rvlac_d    = rvlac_q;
        unexp_d    = 1'b0;
        alive_d    = 1'b1;
        complete_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (alive_q) begin
                    if (req_valid) begin
                        op_d    = req_op;
                        id_d    = req_id;
                        arg_d   = req_data;
                        resp_d  = 32'h0;
                        state_d = S_SEND;
                    end else if (!rx_empty) begin
                        pop_d   = 1'b1;
                        unsol_d = 1'b1;
                        state_d = S_POP;
                    end
                end
            end
            S_SEND: begin
                if (!tx_full) begin
                    if (op_q >= OP_RESET) begin
                        status_d = ST_OK;
                        state_d  = S_FINISH;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!rx_empty) begin
                    pop_d   = 1'b1;
                    unsol_d = 1'b0;
                    state_d = S_POP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_POP: begin
                // First cycle carries the pop strobe; the head packet is valid on the second.
                if (!pop_q) begin
                    cmd_d   = rx_command;
                    rxd_d   = rx_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cmd_q[7]) begin
                    for (int i = 0; i < SLOT_COUNT; i++) begin
                        if (cmd_q[6:0] == 7'(i)) begin
                            slots_d[i*32 +: 32] = rxd_q;
                            valid_d[i]          = 1'b1;
                            upd_d               = 1'b1;
                            upd_id_d            = cmd_q[6:0];
                        end
                    end
                    if (!unsol_q &&
                        ((op_q == OP_UPDATE_SLOT && cmd_q[6:0] == id_q) ||
                         (op_q == OP_UPDATE_ALL && cmd_q[6:0] == 7'(SLOT_COUNT - 1)))) begin
                        complete_c = 1'b1;
                        status_d   = ST_OK;
                    end
                end else if (unsol_q) begin
                    unexp_d = 1'b1;
                end else if (cmd_q == 8'h03 && op_q == OP_PING) begin
                    complete_c = 1'b1;
                    status_d   = ST_OK;
                end else if (cmd_q == 8'h05 && op_q == OP_ASK_SLOTS) begin
                    rsc_d      = rxd_q[7:0];
                    resp_d     = rxd_q;
                    complete_c = 1'b1;
                    status_d   = ST_OK;
                end else if (cmd_q == 8'h06 && op_q == OP_ASK_ACTIONS) begin
                    rvac_d     = rxd_q[7:0];
                    rvlac_d    = rxd_q[15:8];
                    resp_d     = rxd_q;
                    complete_c = 1'b1;
                    status_d   = ST_OK;
                end else if (cmd_q == 8'h09) begin
                    complete_c = 1'b1;
                    status_d   = ST_INVALID_SLOT;
                end else if (cmd_q == 8'h0a) begin
                    complete_c = 1'b1;
                    status_d   = ST_INVALID_ACTION;
                end else if (cmd_q == 8'h0b) begin
                    complete_c = 1'b1;
                    status_d   = ST_UNKNOWN_CMD;
                end else begin
                    unexp_d = 1'b1;
                end
                if (complete_c) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = unsol_q ? S_IDLE : S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            id_q     <= '0;
            arg_q    <= '0;
            cnt_q    <= '0;
            pop_q    <= 1'b0;
            unsol_q  <= 1'b0;
            cmd_q    <= '0;
            rxd_q    <= '0;
            status_q <= '0;
            resp_q   <= '0;
            slots_q  <= '0;
            valid_q  <= '0;
            upd_q    <= 1'b0;
            upd_id_q <= '0;
            rsc_q    <= '0;
            rvac_q   <= '0;
            rvlac_q  <= '0;
            unexp_q  <= 1'b0;
            alive_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            id_q     <= id_d;
            arg_q    <= arg_d;
            cnt_q    <= cnt_d;
            pop_q    <= pop_d;
            unsol_q  <= unsol_d;
            cmd_q    <= cmd_d;
            rxd_q    <= rxd_d;
            status_q <= status_d;
            resp_q   <= resp_d;
            slots_q  <= slots_d;
            valid_q  <= valid_d;
            upd_q    <= upd_d;
            upd_id_q <= upd_id_d;
            rsc_q    <= rsc_d;
            rvac_q   <= rvac_d;
            rvlac_q  <= rvlac_d;
            unexp_q  <= unexp_d;
            alive_q  <= alive_d;
        end
    end

    // Command encoding of the latched request, presented only while sending
    always_comb begin
        tx_command = 8'h00;
        tx_data    = 32'h0;
        if (state_q == S_SEND) begin
            case (op_q)
                OP_PING:        tx_command = 8'h01;
                OP_UPDATE_SLOT: begin
                    tx_command = 8'h02;
                    tx_data    = {25'h0, id_q};
                end
                OP_UPDATE_ALL:  tx_command = 8'h03;
                OP_ASK_SLOTS:   tx_command = 8'h04;
                OP_ASK_ACTIONS: tx_command = 8'h05;
                OP_RESET:       tx_command = 8'h55;
                OP_VAR_ACTION:  begin
                    tx_command = {2'b11, id_q[5:0]};
                    tx_data    = arg_q;
                end
                default:        tx_command = {2'b10, id_q[5:0]};
            endcase
        end
    end

    assign req_ready                   = alive_q && (state_q == S_IDLE);
    assign tx_push_packet              = (state_q == S_SEND) && !tx_full;
    assign rx_pop_packet               = pop_q;
    assign done                        = (state_q == S_FINISH);
    assign resp_status                 = status_q;
    assign resp_data                   = resp_q;
    assign slot_values                 = slots_q;
    assign slot_valid                  = valid_q;
    assign slot_update                 = upd_q;
    assign slot_update_id              = upd_id_q;
    assign remote_slot_count           = rsc_q;
    assign remote_var_action_count     = rvac_q;
    assign remote_varless_action_count = rvlac_q;
    assign rx_unexpected               = unexp_q;

endmodule

// File: tb/tb_hedios_host.sv
// tb/tb_hedios_host.sv - self-checking bench for hedios_host with an endpoint FIFO model
module tb_hedios_host;

    localparam int SC = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_op = '0;
    logic [6:0]      req_id = '0;
    logic [31:0]     req_data = '0;
    logic            tx_full = 1'b0;
    logic [7:0]      tx_command;
    logic [31:0]     tx_data;
    logic            tx_push_packet;
    logic            rx_empty = 1'b1;
    logic [7:0]      rx_command = '0;
    logic [31:0]     rx_data = '0;
    logic            rx_pop_packet;
    logic            done;
    logic [2:0]      resp_status;
    logic [31:0]     resp_data;
    logic [SC*32-1:0] slot_values;
    logic [SC-1:0]   slot_valid;
    logic            slot_update;
    logic [6:0]      slot_update_id;
    logic [7:0]      remote_slot_count;
    logic [7:0]      remote_var_action_count;
    logic [7:0]      remote_varless_action_count;
    logic            rx_unexpected;

    hedios_host #(.SLOT_COUNT(SC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_id(req_id), .req_data(req_data),
        .tx_full(tx_full), .tx_command(tx_command), .tx_data(tx_data),
        .tx_push_packet(tx_push_packet),
        .rx_empty(rx_empty), .rx_command(rx_command), .rx_data(rx_data),
        .rx_pop_packet(rx_pop_packet),
        .done(done), .resp_status(resp_status), .resp_data(resp_data),
        .slot_values(slot_values), .slot_valid(slot_valid),
        .slot_update(slot_update), .slot_update_id(slot_update_id),
        .remote_slot_count(remote_slot_count),
        .remote_var_action_count(remote_var_action_count),
        .remote_varless_action_count(remote_varless_action_count),
        .rx_unexpected(rx_unexpected)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  c;
        logic [31:0] d;
    } pkt_t;
    pkt_t rxq[$];

    int checks = 0;
    int errors = 0;

    // observations collected by the monitor
    int          push_cnt = 0, push_cyc = 0;
    logic [7:0]  last_cmd = '0;
    logic [31:0] last_data = '0;
    int          pop_cnt = 0, pop_cyc = 0, pop_consec = 0, pop_bad = 0;
    logic        prev_pop = 1'b0;
    int          rxlow_cyc = 0;
    int          done_cnt = 0, done_cyc = 0, done_pops = 0;
    logic [2:0]  done_status = '0;
    logic [31:0] done_resp = '0;
    int          upd_cnt = 0;
    logic [6:0]  last_upd_id = '0;
    int          unexp_cnt = 0;

    // reference mirror
    logic [31:0]   m_slot[SC];
    logic [SC-1:0] m_valid;

    // Endpoint model: samples DUT strobes mid-cycle and serves the rx FIFO
    always @(negedge clk) begin
        if (tx_push_packet) begin
            push_cnt++; push_cyc = cyc; last_cmd = tx_command; last_data = tx_data;
        end
        if (rx_pop_packet) begin
            pop_cnt++; pop_cyc = cyc;
            if (prev_pop) pop_consec++;
            if (rxq.size() == 0) pop_bad++;
            else begin
                rx_command = rxq[0].c;
                rx_data    = rxq[0].d;
                void'(rxq.pop_front());
            end
        end
        prev_pop = rx_pop_packet;
        if (done) begin
            done_cnt++; done_cyc = cyc; done_status = resp_status;
            done_resp = resp_data; done_pops = pop_cnt;
        end
        if (slot_update) begin
            upd_cnt++; last_upd_id = slot_update_id;
        end
        if (rx_unexpected) unexp_cnt++;
        if (rx_empty && rxq.size() != 0) rxlow_cyc = cyc;
        rx_empty = (rxq.size() == 0);
    end

    function automatic logic [39:0] encode(input logic [2:0] op, input logic [6:0] id,
                                           input logic [31:0] d);
        case (op)
            3'd0:    return {8'h01, 32'h0};
            3'd1:    return {8'h02, 25'h0, id};
            3'd2:    return {8'h03, 32'h0};
            3'd3:    return {8'h04, 32'h0};
            3'd4:    return {8'h05, 32'h0};
            3'd5:    return {8'h55, 32'h0};
            3'd6:    return {2'b11, id[5:0], d};
            default: return {2'b10, id[5:0], 32'h0};
        endcase
    endfunction

    task automatic send_pkt(input logic [7:0] c, input logic [31:0] d);
        pkt_t p;
        p.c = c;
        p.d = d;
        rxq.push_back(p);
    endtask

    task automatic issue(input logic [2:0] op, input logic [6:0] id, input logic [31:0] d,
                         output int c0);
        int n = 0;
        @(posedge clk); #1;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL issue_ready: req_ready %b required 1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_id = id; req_data = d;
        c0 = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_push(input int prev);
        int n = 0;
        while (push_cnt == prev && n < 100) begin
            @(posedge clk); n++;
        end
        if (push_cnt == prev) begin
            checks++; errors++; $display("FAIL wait_push: no push within 100 cycles");
        end
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_cnt == prev && n < 200) begin
            @(posedge clk); n++;
        end
        if (done_cnt == prev) begin
            checks++; errors++; $display("FAIL wait_done: no done within 200 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rxq.delete(); req_valid = 1'b0; tx_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, tx_push_packet, rx_pop_packet, done, slot_update, rx_unexpected} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes: got %b required 000000",
                {req_ready, tx_push_packet, rx_pop_packet, done, slot_update, rx_unexpected});
        end
        checks++;
        if (slot_values !== '0 || slot_valid !== '0) begin
            errors++; $display("FAIL reset_mirror: values %h valid %b required 0", slot_values, slot_valid);
        end
        checks++;
        if ({remote_slot_count, remote_var_action_count, remote_varless_action_count,
             resp_status, resp_data, tx_command, tx_data} !== '0) begin
            errors++; $display("FAIL reset_regs: counts %h %h %h status %0d data %h required 0",
                remote_slot_count, remote_var_action_count, remote_varless_action_count,
                resp_status, resp_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < SC; i++) m_slot[i] = 32'h0;
        m_valid = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: req_ready %b required 1", req_ready);
        end
    endtask

    task automatic test_ping();
        int c0, p0, q0, d0;
        p0 = push_cnt; q0 = pop_cnt; d0 = done_cnt;
        issue(3'd0, 7'd0, 32'h0, c0);
        wait_push(p0);
        checks++;
        if ({last_cmd, last_data} !== 40'h01_0000_0000 || push_cyc != c0 + 1) begin
            errors++; $display("FAIL ping_push: cmd %h data %h cycle %0d required 01 0 cycle %0d",
                last_cmd, last_data, push_cyc, c0 + 1);
        end
        repeat (10) @(posedge clk); #1;
        send_pkt(8'h03, 32'h0);
        wait_done(d0);
        checks++;
        if (push_cnt != p0 + 1 || pop_cnt != q0 + 1) begin
            errors++; $display("FAIL ping_counts: pushes %0d pops %0d required 1 1", push_cnt - p0, pop_cnt - q0);
        end
        checks++;
        if (pop_cyc != rxlow_cyc + 1 || done_cyc != pop_cyc + 3) begin
            errors++; $display("FAIL ping_latency: pop-avail %0d done-pop %0d required 1 3",
                pop_cyc - rxlow_cyc, done_cyc - pop_cyc);
        end
        checks++;
        if (done_status !== 3'd0 || done_resp !== 32'h0) begin
            errors++; $display("FAIL ping_resp: status %0d data %h required 0 0", done_status, done_resp);
        end
    endtask

    task automatic test_update_slot();
        int c0, p0, d0, u0;
        p0 = push_cnt; d0 = done_cnt; u0 = upd_cnt;
        issue(3'd1, 7'd2, 32'h0, c0);
        wait_push(p0);
        checks++;
        if ({last_cmd, last_data} !== encode(3'd1, 7'd2, 32'h0)) begin
            errors++; $display("FAIL upd_push: got %h %h required 02 00000002", last_cmd, last_data);
        end
        send_pkt(8'h82, 32'hDEADBEEF);
        wait_done(d0);
        m_slot[2] = 32'hDEADBEEF; m_valid[2] = 1'b1;
        checks++;
        if (upd_cnt != u0 + 1 || last_upd_id !== 7'd2 || done_status !== 3'd0) begin
            errors++; $display("FAIL upd_done: updates %0d id %0d status %0d required 1 2 0",
                upd_cnt - u0, last_upd_id, done_status);
        end
        for (int i = 0; i < SC; i++) begin
            checks++;
            if (slot_values[i*32 +: 32] !== m_slot[i]) begin
                errors++; $display("FAIL upd_mirror[%0d]: got %h required %h", i, slot_values[i*32 +: 32], m_slot[i]);
            end
        end
        checks++;
        if (slot_valid !== m_valid) begin
            errors++; $display("FAIL upd_valid: got %b required %b", slot_valid, m_valid);
        end
    endtask

    task automatic test_update_all();
        int c0, p0, q0, d0, u0;
        p0 = push_cnt; q0 = pop_cnt; d0 = done_cnt; u0 = upd_cnt;
        issue(3'd2, 7'd0, 32'h0, c0);
        wait_push(p0);
        checks++;
        if (last_cmd !== 8'h03) begin
            errors++; $display("FAIL all_push: cmd %h required 03", last_cmd);
        end
        for (int i = 0; i < SC; i++) begin
            send_pkt(8'h80 + 8'(i), 32'(i + 1));
            m_slot[i] = 32'(i + 1); m_valid[i] = 1'b1;
        end
        wait_done(d0);
        checks++;
        if (upd_cnt != u0 + SC || done_pops != q0 + SC || done_status !== 3'd0) begin
            errors++; $display("FAIL all_done: updates %0d pops-at-done %0d status %0d required %0d %0d 0",
                upd_cnt - u0, done_pops - q0, done_status, SC, SC);
        end
        checks++;
        if (slot_valid !== 4'hF) begin
            errors++; $display("FAIL all_valid: got %b required 1111", slot_valid);
        end
        for (int i = 0; i < SC; i++) begin
            checks++;
            if (slot_values[i*32 +: 32] !== m_slot[i]) begin
                errors++; $display("FAIL all_mirror[%0d]: got %h required %h", i, slot_values[i*32 +: 32], m_slot[i]);
            end
        end
    endtask

    task automatic test_ask_counts();
        int c0, d0;
        logic [31:0] r;
        d0 = done_cnt;
        issue(3'd4, 7'd0, 32'h0, c0);
        send_pkt(8'h06, 32'h0000_0305);
        wait_done(d0);
        checks++;
        if (remote_var_action_count !== 8'd5 || remote_varless_action_count !== 8'd3 ||
            done_resp !== 32'h305 || done_status !== 3'd0) begin
            errors++; $display("FAIL ask_actions: var %0d varless %0d resp %h status %0d required 5 3 305 0",
                remote_var_action_count, remote_varless_action_count, done_resp, done_status);
        end
        r = $urandom;
        d0 = done_cnt;
        issue(3'd3, 7'd0, 32'h0, c0);
        send_pkt(8'h05, r);
        wait_done(d0);
        checks++;
        if (remote_slot_count !== r[7:0] || done_resp !== r || remote_var_action_count !== 8'd5) begin
            errors++; $display("FAIL ask_slots: count %h resp %h var %0d required %h %h 5",
                remote_slot_count, done_resp, remote_var_action_count, r[7:0], r);
        end
    endtask

    task automatic test_var_action();
        int c0, d0;
        d0 = done_cnt;
        tx_full = 1'b1;
        issue(3'd6, 7'd7, 32'h1234, c0);
        repeat (3) @(posedge clk); #1;
        tx_full = 1'b0;
        wait_done(d0);
        checks++;
        if ({last_cmd, last_data} !== 40'hC7_0000_1234 || push_cyc != c0 + 4 || done_cyc != c0 + 5) begin
            errors++; $display("FAIL var_action: cmd %h data %h push@%0d done@%0d required C7 1234 @4 @5",
                last_cmd, last_data, push_cyc - c0, done_cyc - c0);
        end
    endtask

    task automatic test_fire_random();
        for (int k = 0; k < 12; k++) begin
            int c0, d0, nf;
            logic [2:0]  op;
            logic [6:0]  id;
            logic [31:0] d;
            op = 3'(5 + $urandom_range(0, 2));
            id = 7'($urandom);
            d  = $urandom;
            nf = $urandom_range(0, 3);
            d0 = done_cnt;
            tx_full = (nf != 0);
            issue(op, id, d, c0);
            if (nf != 0) begin
                repeat (nf) @(posedge clk); #1;
                tx_full = 1'b0;
            end
            wait_done(d0);
            checks++;
            if ({last_cmd, last_data} !== encode(op, id, d)) begin
                errors++; $display("FAIL fire_enc op%0d: got %h %h required %h", op, last_cmd, last_data, encode(op, id, d));
            end
            checks++;
            if (push_cyc != c0 + 1 + nf || done_cyc != push_cyc + 1 || done_status !== 3'd0) begin
                errors++; $display("FAIL fire_timing op%0d: push@%0d done@%0d status %0d required @%0d @%0d 0",
                    op, push_cyc - c0, done_cyc - c0, done_status, 1 + nf, 2 + nf);
            end
        end
    endtask

    task automatic test_errors();
        logic [2:0] ops[3] = '{3'd1, 3'd4, 3'd0};
        logic [7:0] cmds[3] = '{8'h09, 8'h0a, 8'h0b};
        logic [2:0] sts[3] = '{3'd2, 3'd3, 3'd4};
        for (int k = 0; k < 3; k++) begin
            int c0, d0;
            d0 = done_cnt;
            issue(ops[k], 7'd1, 32'h0, c0);
            send_pkt(cmds[k], $urandom);
            wait_done(d0);
            checks++;
            if (done_status !== sts[k] || done_resp !== 32'h0) begin
                errors++; $display("FAIL err_status %h: status %0d data %h required %0d 0",
                    cmds[k], done_status, done_resp, sts[k]);
            end
        end
    endtask

    task automatic test_out_of_range();
        int c0, d0, u0;
        d0 = done_cnt; u0 = upd_cnt;
        issue(3'd1, 7'd5, 32'h0, c0);
        send_pkt(8'h85, $urandom);
        wait_done(d0);
        checks++;
        if (done_status !== 3'd0 || upd_cnt != u0 || slot_valid !== m_valid) begin
            errors++; $display("FAIL oor_slot: status %0d updates %0d valid %b required 0 0 %b",
                done_status, upd_cnt - u0, slot_valid, m_valid);
        end
    endtask

    task automatic test_unsolicited();
        int d0, u0, x0, n;
        logic [31:0] r;
        d0 = done_cnt; u0 = upd_cnt; x0 = unexp_cnt;
        r = $urandom;
        @(posedge clk); #1;
        send_pkt(8'h81, r);
        m_slot[1] = r; m_valid[1] = 1'b1;
        n = 0;
        while (upd_cnt == u0 && n < 50) begin @(posedge clk); n++; end
        repeat (4) @(posedge clk);
        checks++;
        if (upd_cnt != u0 + 1 || last_upd_id !== 7'd1 || done_cnt != d0 || unexp_cnt != x0) begin
            errors++; $display("FAIL unsol_slot: updates %0d id %0d dones %0d unexp %0d required 1 1 0 0",
                upd_cnt - u0, last_upd_id, done_cnt - d0, unexp_cnt - x0);
        end
        checks++;
        if (slot_values[63:32] !== m_slot[1] || slot_valid !== m_valid) begin
            errors++; $display("FAIL unsol_mirror: got %h %b required %h %b", slot_values[63:32], slot_valid, m_slot[1], m_valid);
        end
        #1;
        send_pkt(8'h03, 32'h0);
        n = 0;
        while (unexp_cnt == x0 && n < 50) begin @(posedge clk); n++; end
        repeat (2) @(posedge clk);
        checks++;
        if (unexp_cnt != x0 + 1 || done_cnt != d0) begin
            errors++; $display("FAIL unsol_other: unexp %0d dones %0d required 1 0", unexp_cnt - x0, done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        int c0, p0, d0, x0;
        d0 = done_cnt; p0 = push_cnt;
        issue(3'd0, 7'd0, 32'h0, c0);
        wait_done(d0);
        checks++;
        if (done_status !== 3'd1 || done_cyc != push_cyc + TO + 1) begin
            errors++; $display("FAIL timeout_plain: status %0d done-push %0d required 1 %0d",
                done_status, done_cyc - push_cyc, TO + 1);
        end
        d0 = done_cnt; p0 = push_cnt; x0 = unexp_cnt;
        issue(3'd0, 7'd0, 32'h0, c0);
        wait_push(p0);
        repeat (5) @(posedge clk); #1;
        send_pkt(8'h04, 32'h0);
        wait_done(d0);
        checks++;
        if (done_status !== 3'd1 || unexp_cnt != x0 + 1 || done_cyc != rxlow_cyc + 4 + TO) begin
            errors++; $display("FAIL timeout_restart: status %0d unexp %0d done-avail %0d required 1 1 %0d",
                done_status, unexp_cnt - x0, done_cyc - rxlow_cyc, 4 + TO);
        end
    endtask

    task automatic test_reset_midop();
        int c0, p0, q0, d0;
        p0 = push_cnt;
        issue(3'd0, 7'd0, 32'h0, c0);
        wait_push(p0);
        repeat (3) @(posedge clk); #1;
        p0 = push_cnt; q0 = pop_cnt; d0 = done_cnt;
        rst = 1'b1;
        send_pkt(8'h03, 32'h0);
        repeat (4) @(posedge clk);
        checks++;
        if (push_cnt != p0 || pop_cnt != q0 || done_cnt != d0 || slot_valid !== '0) begin
            errors++; $display("FAIL midop_reset: pushes %0d pops %0d dones %0d valid %b required 0 0 0 0",
                push_cnt - p0, pop_cnt - q0, done_cnt - d0, slot_valid);
        end
        #1;
        rxq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < SC; i++) m_slot[i] = 32'h0;
        m_valid = '0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || done_cnt != d0 || pop_cnt != q0) begin
            errors++; $display("FAIL midop_after: ready %b dones %0d pops %0d required 1 0 0",
                req_ready, done_cnt - d0, pop_cnt - q0);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (pop_consec != 0 || pop_bad != 0) begin
            errors++; $display("FAIL pop_protocol: consecutive %0d on-empty %0d required 0 0", pop_consec, pop_bad);
        end
    endtask

    initial begin
        test_reset();
        test_ping();
        test_update_slot();
        test_update_all();
        test_ask_counts();
        test_var_action();
        test_fire_random();
        test_errors();
        test_out_of_range();
        test_unsolicited();
        test_timeout();
        test_reset_midop();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
